// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with a double-buffered display image.
// It supports per-digit enable, decimal points, leading-zero blanking and configurable pin polarity.
module seg7_scan_driver #(
   parameter int DIGITS         = 8,
   parameter int CLK_DIV        = 100000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     en_in,
   input  logic                  load,
   input  logic                  lz_suppress,
   output logic [7:0]            o_seg,
   output logic [DIGITS-1:0]     o_sel,
   output logic                  frame_done
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [7:0]        SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [DIGITS-1:0] SEL_OFF    = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

   logic [PW-1:0]       r_presc;
   logic [IW-1:0]       r_idx;
   logic [4*DIGITS-1:0] r_pend_data;
   logic [DIGITS-1:0]   r_pend_dp;
   logic [DIGITS-1:0]   r_pend_en;
   logic                r_pend_valid;
   logic [4*DIGITS-1:0] r_act_data;
   logic [DIGITS-1:0]   r_act_dp;
   logic [DIGITS-1:0]   r_act_en;
   logic [7:0]          r_seg;
   logic [DIGITS-1:0]   r_sel;

   logic                w_tick;
   logic                w_wrap;
   logic [3:0]          w_nib [DIGITS];
   logic [DIGITS-1:0]   w_dz;
   logic [DIGITS-1:0]   w_supp;
   logic [7:0]          w_seg_ah;
   logic [DIGITS-1:0]   w_sel_ah;

   function automatic logic [6:0] f_decode(input logic [3:0] nib);
      case (nib)
         4'h0: f_decode = 7'h3F;
         4'h1: f_decode = 7'h06;
         4'h2: f_decode = 7'h5B;
         4'h3: f_decode = 7'h4F;
         4'h4: f_decode = 7'h66;
         4'h5: f_decode = 7'h6D;
         4'h6: f_decode = 7'h7D;
         4'h7: f_decode = 7'h07;
         4'h8: f_decode = 7'h7F;
         4'h9: f_decode = 7'h6F;
         4'hA: f_decode = 7'h77;
         4'hB: f_decode = 7'h7C;
         4'hC: f_decode = 7'h39;
         4'hD: f_decode = 7'h5E;
         4'hE: f_decode = 7'h79;
         default: f_decode = 7'h71;
      endcase
   endfunction

   assign w_tick     = (r_presc == PRESC_LAST);
   assign w_wrap     = w_tick && (r_idx == IDX_LAST);
   assign frame_done = w_wrap & reset;
   assign o_seg      = r_seg;
   assign o_sel      = r_sel;

   // A digit is blank-eligible when it and every digit above it read as zero (disabled counts as zero).
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign w_nib[gi] = r_act_data[4*gi +: 4];
         assign w_dz[gi]  = !r_act_en[gi] || (w_nib[gi] == 4'h0);
         if (gi == 0) begin : g_lsd
            assign w_supp[gi] = 1'b0;
         end else begin : g_upper
            assign w_supp[gi] = &w_dz[DIGITS-1:gi];
         end
      end
   endgenerate

   always_comb begin
      w_seg_ah = 8'h00;
      w_sel_ah = '0;
      if (r_act_en[r_idx]) begin
         w_sel_ah[r_idx] = 1'b1;
         w_seg_ah[7]     = r_act_dp[r_idx];
         if (!(lz_suppress && w_supp[r_idx]))
            w_seg_ah[6:0] = f_decode(w_nib[r_idx]);
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_seg   <= SEG_OFF;
         r_sel   <= SEL_OFF;
      end else begin
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick)
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
         // XOR with the idle pattern turns the active-high image into pin polarity.
         r_seg <= w_seg_ah ^ SEG_OFF;
         r_sel <= w_sel_ah ^ SEL_OFF;
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_pend_data  <= '0;
         r_pend_dp    <= '0;
         r_pend_en    <= '0;
         r_pend_valid <= 1'b0;
         r_act_data   <= '0;
         r_act_dp     <= '0;
         r_act_en     <= '1;
      end else begin
         if (load) begin
            r_pend_data <= data;
            r_pend_dp   <= dp_in;
            r_pend_en   <= en_in;
         end
         // The active image only ever changes on the frame boundary, so a frame is never torn.
         if (w_wrap) begin
            if (load) begin
               r_act_data <= data;
               r_act_dp   <= dp_in;
               r_act_en   <= en_in;
            end else if (r_pend_valid) begin
               r_act_data <= r_pend_data;
               r_act_dp   <= r_pend_dp;
               r_act_en   <= r_pend_en;
            end
            r_pend_valid <= 1'b0;
         end else if (load) begin
            r_pend_valid <= 1'b1;
         end
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised time-multiplexed seven-segment display driver producing the board-level o_seg/o_sel pins from a packed hex value (e.g. the CPU's PC or a register-file tap).
Generalises the fixed 8-digit scanner: configurable digit count, scan rate and pin polarity.
Adds per-digit enable, decimal points, leading-zero suppression and tear-free double-buffered updates.
Sits between the CPU/top-level dataflow and the board pins.

Parameters:
DIGITS, 8, number of multiplexed digits (1..16)
CLK_DIV, 100000, clk_in cycles per digit slot (>=1)
SEG_ACTIVE_LOW, 1, 1: o_seg bits driven low to light
SEL_ACTIVE_LOW, 1, 1: o_sel bit driven low to select

Ports:
clk_in  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
data  input  4*DIGITS  packed hex nibbles, nibble i = digit i (digit 0 rightmost)
dp_in  input  DIGITS  decimal-point request per digit
en_in  input  DIGITS  digit enable per digit
load  input  1  capture data/dp_in/en_in into pending buffer
lz_suppress  input  1  1: blank leading zero digits
o_seg  output  8  segments, bit0=a..bit6=g, bit7=dp
o_sel  output  DIGITS  digit select, bit i = digit i
frame_done  output  1  one-cycle pulse at end of each full scan

Behaviour:
- Reset (reset=0, async): prescaler=0, scan_idx=0, pending_valid=0, active data=0, active dp=0, active en=all 1; o_seg and o_sel all inactive (per polarity params); frame_done=0.
- Prescaler counts 0..CLK_DIV-1 and wraps; tick asserted in the cycle count==CLK_DIV-1. CLK_DIV=1: tick every cycle.
- On tick: scan_idx increments; wraps DIGITS-1 -> 0. frame_done=1 for exactly the cycle with tick and scan_idx==DIGITS-1.
- load=1: data/dp_in/en_in copied to pending regs; pending_valid=1. Repeated loads before a wrap overwrite the pending regs; last one wins.
- On wrap tick with pending_valid=1: pending copied to active regs; pending_valid cleared. The active buffer never changes mid-frame.
- load coincident with wrap tick: the input values go straight to the active regs; pending_valid ends 0.
- Outputs are registered. They reflect the new scan_idx one clk_in cycle after scan_idx changes. First valid drive is the first clock edge after reset deasserts, showing digit 0.
- Decode, active-high internal form: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. bit7 = active dp[idx]. Inverted when SEG_ACTIVE_LOW=1.
- o_sel: exactly one bit active (bit scan_idx) when that digit is shown. All bits inactive when the digit is disabled (en=0): o_seg all off, slot still consumes its time.
- Leading-zero suppression (lz_suppress=1), digit i suppressed when:
  - the nibbles of digits i..DIGITS-1 are all 0, and
  - i != 0 (digit 0 is never suppressed).
- A suppressed digit keeps o_sel active; segments a-g are off; dp is still shown if its bit is set.
- lz_suppress is sampled live (not buffered).
- Disabled digits count as zero for suppression.

Test Plan:
- Reset and first frame: DIGITS=8, CLK_DIV=4, polarity params 1, reset low then high with active regs at reset values -> o_sel=8'hFE, o_seg=8'hC0 one cycle after release. Each subsequent digit selected for 4 cycles (FD, FB, ...).
- Tear-free load: load data=32'h1234ABCD mid-frame -> remaining digits keep showing 0. After next frame_done, digit0 o_seg=~8'h5E=8'hA1, digit7 o_seg=~8'h06=8'hF9.
- Coincident load and wrap: assert load in the frame_done cycle with data=32'h00000008 -> the next frame's digit0 shows 8'h80, and no additional frame delay occurs.
- Leading-zero suppression: data=32'h00000105, lz_suppress=1 -> digits 7..3 segments 8'hFF with select active, digits 2..0 show 1,0,5. Setting dp_in[5]=1 -> digit5 shows 8'h7F.
- Digit disable and CLK_DIV=1: en_in=8'b1111_0111 -> slot 3 has o_sel=8'hFF, o_seg=8'hFF. With CLK_DIV=1, the slot advances every cycle and frame_done pulses every 8 cycles.
- Async reset mid-frame: pull reset low at scan_idx=5 between clock edges -> outputs go inactive immediately and the pending load is discarded. After release, scanning restarts at digit 0 showing 0.
